vga_timing_gen: RTL and testbench

Parametrised successor to the team's fixed 640x480 sync generator.
- Generates hsync/vsync, a display-enable flag and x/y pixel coordinates for any VESA-style mode.
- Has an internal pixel-tick divider, so it runs directly from the system clock (e.g. 100 MHz → 25 MHz pixel rate).
- Emits line/frame start strobes, and all outputs are coincident in the same cycle.
- Feeds the pixel/RGB generators and the VGA output pins.

---
 rtl/vga_timing_pkg.sv | 53 +++++
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing_pixel_tick_div.sv | 26 ++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants, sync-polarity encoding and the region decode used by the timing generator.
package vga_timing_pkg;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // 640x480@60 (25.175 MHz nominal pixel clock)
  localparam int M640_H_DISPLAY = 640;
  localparam int M640_H_FRONT   = 16;
  localparam int M640_H_SYNC    = 96;
  localparam int M640_H_BACK    = 48;
  localparam int M640_V_DISPLAY = 480;
  localparam int M640_V_FRONT   = 10;
  localparam int M640_V_SYNC    = 2;
  localparam int M640_V_BACK    = 33;

  // 800x600@60 (40 MHz pixel clock, positive syncs)
  localparam int M800_H_DISPLAY = 800;
  localparam int M800_H_FRONT   = 40;
  localparam int M800_H_SYNC    = 128;
  localparam int M800_H_BACK    = 88;
  localparam int M800_V_DISPLAY = 600;
  localparam int M800_V_FRONT   = 1;
  localparam int M800_V_SYNC    = 4;
  localparam int M800_V_BACK    = 23;

  typedef enum logic [1:0] {
    REG_DISPLAY,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_e;

  function automatic int span_total(int d, int f, int s, int b);
    return d + f + s + b;
  endfunction

  function automatic int sync_start(int d, int f);
    return d + f;
  endfunction

  function automatic int sync_end(int d, int f, int s);
    return d + f + s;
  endfunction

  function automatic region_e region_of(int pos, int d, int f, int s);
    if (pos < d)                    return REG_DISPLAY;
    else if (pos < sync_start(d, f)) return REG_FRONT;
    else if (pos < sync_end(d, f, s)) return REG_SYNC;
    else                            return REG_BACK;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing bundle between the sync generator (master) and its consumers (slave).
interface vga_timing_if #(
  parameter int CW      = 12,
  parameter int FRAME_W = 16
);
  logic               enable;
  logic               p_tick;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [CW-1:0]      x;
  logic [CW-1:0]      y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  enable,
    output p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_count
  );

  modport slave (
    output enable,
    input  p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_pixel_tick_div.sv
// Pixel-rate strobe divider: p_tick fires once every CLK_DIV enabled clocks and freezes with enable.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic p_tick
);
  // With CLK_DIV=1 the counter degenerates to a constant 0, so p_tick simply follows enable.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
    end
  end

  assign p_tick = enable && (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style sync generator with internal pixel divider and zero-skew registered outputs.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = M640_H_DISPLAY,
  parameter int H_FRONT   = M640_H_FRONT,
  parameter int H_SYNC    = M640_H_SYNC,
  parameter int H_BACK    = M640_H_BACK,
  parameter int V_DISPLAY = M640_V_DISPLAY,
  parameter int V_FRONT   = M640_V_FRONT,
  parameter int V_SYNC    = M640_V_SYNC,
  parameter int V_BACK    = M640_V_BACK,
  parameter bit HSYNC_POL = POL_ACTIVE_LOW,
  parameter bit VSYNC_POL = POL_ACTIVE_LOW,
  parameter int CLK_DIV   = 4,
  parameter int CW        = 12,
  parameter int FRAME_W   = 16
) (
  input logic        clk,
  input logic        reset_n,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic          p_tick;
  logic [CW-1:0] x_q, y_q, x_n, y_n;
  logic          video_on_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  region_e       h_reg_n, v_reg_n;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (bus.enable),
    .p_tick  (p_tick)
  );

  always_comb begin
    x_n = x_q + CW'(1);
    y_n = y_q;
    if (x_q == CW'(H_TOTAL - 1)) begin
      x_n = '0;
      y_n = (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + CW'(1);
    end
  end

  assign h_reg_n = region_of(int'(x_n), H_DISPLAY, H_FRONT, H_SYNC);
  assign v_reg_n = region_of(int'(y_n), V_DISPLAY, V_FRONT, V_SYNC);

  // Flags decode the next counts so they land in the same clk as the new x/y; reset parks on the last pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= CW'(H_TOTAL - 1);
      y_q           <= CW'(V_TOTAL - 1);
      video_on_q    <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (p_tick) begin
        x_q           <= x_n;
        y_q           <= y_n;
        video_on_q    <= (h_reg_n == REG_DISPLAY) && (v_reg_n == REG_DISPLAY);
        hsync_q       <= (h_reg_n == REG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_q       <= (v_reg_n == REG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        line_start_q  <= (x_n == '0);
        frame_start_q <= (x_n == '0) && (y_n == '0);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else if (frame_start_q) begin
      frame_count_q <= frame_count_q + FRAME_W'(1);
    end
  end

  assign bus.frame_count = frame_count_q;
`else
  assign bus.frame_count = '0;
`endif

  assign bus.p_tick      = p_tick;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.video_on    = video_on_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on two tiny modes (divided active-low, undivided active-high).
// Covers reset state, pixel walk, freeze, mid-frame async reset and the optional frame counter.
module tb_vga_timing_gen;
  localparam int CW = 8;
  localparam int FW = 2;

  // Mode A: 8/2/3/2 x 5/1/2/2, CLK_DIV=4, active-low syncs; mode B: 10/2/4/3 x 6/1/2/2, CLK_DIV=1, active-high.
  localparam int A_HD = 8,  A_HF = 2, A_HS = 3, A_HB = 2, A_VD = 5, A_VF = 1, A_VS = 2, A_VB = 2, A_DIV = 4;
  localparam int A_HT = 15, A_VT = 10;
  localparam int B_HD = 10, B_HF = 2, B_HS = 4, B_HB = 3, B_VD = 6, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_HT = 19, B_VT = 11;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic          von;
    logic          ls;
    logic          fs;
    logic [FW-1:0] fc;
  } exp_t;

  localparam exp_t RST_A = '{x: 8'd14, y: 8'd9,  hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0, fc: 2'd0};
  localparam exp_t RST_B = '{x: 8'd18, y: 8'd10, hs: 1'b0, vs: 1'b0, von: 1'b0, ls: 1'b0, fs: 1'b0, fc: 2'd0};

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic en_a    = 1'b0;
  logic en_b    = 1'b0;

  int   n_pass  = 0;
  int   n_total = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t last_a, last_b, act_a, act_b, exp_a, exp_b;
  logic mon_a = 1'b0, mon_b = 1'b0, upd_a = 1'b0, upd_b = 1'b0;
  int   div_a = 0, popped_a = 0, cyc_a = 0, stall_a = 0, fs_cyc_a = -1, fs_stall_a = 0;
  int   cyc_b = 0, fs_cyc_b = -1;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(CW), .FRAME_W(FW)) bus_a ();
  vga_timing_if #(.CW(CW), .FRAME_W(FW)) bus_b ();

  assign bus_a.enable = en_a;
  assign bus_b.enable = en_b;

  vga_timing_gen #(
    .H_DISPLAY(A_HD), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_DISPLAY(A_VD), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(A_DIV), .CW(CW), .FRAME_W(FW)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CW(CW), .FRAME_W(FW)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic failNow(input string name);
    n_total++;
    $display("[TB] FAIL %s actual=timeout_or_extra required=event", name);
  endtask

  // Expected pixel walk starting at (0,0); frame_count is the number of frame starts already seen.
  task automatic pushWalk(input int inst, input int n);
    int hd, hf, hsn, vd, vf, vsn, ht, vt;
    logic pol;
    if (inst == 0) begin
      hd = A_HD; hf = A_HF; hsn = A_HS; vd = A_VD; vf = A_VF; vsn = A_VS; ht = A_HT; vt = A_VT; pol = 1'b0;
    end else begin
      hd = B_HD; hf = B_HF; hsn = B_HS; vd = B_VD; vf = B_VF; vsn = B_VS; ht = B_HT; vt = B_VT; pol = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   px, py;
      px    = i % ht;
      py    = (i / ht) % vt;
      e.x   = CW'(px);
      e.y   = CW'(py);
      e.hs  = (px >= hd + hf && px < hd + hf + hsn) ? pol : ~pol;
      e.vs  = (py >= vd + vf && py < vd + vf + vsn) ? pol : ~pol;
      e.von = (px < hd) && (py < vd);
      e.ls  = (px == 0);
      e.fs  = (px == 0) && (py == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      e.fc  = FW'((i + ht * vt - 1) / (ht * vt));
`else
      e.fc  = '0;
`endif
      if (inst == 0) q_a.push_back(e);
      else           q_b.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int n_a, input int n_b);
    pushWalk(0, n_a);
    pushWalk(1, n_b);
    last_a = RST_A; last_b = RST_B;
    div_a = 0; popped_a = 0; cyc_a = 0; stall_a = 0; fs_cyc_a = -1; fs_stall_a = 0;
    cyc_b = 0; fs_cyc_b = -1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    en_a    = 1'b1;
    en_b    = 1'b1;
    mon_a   = 1'b1;
    mon_b   = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rst_a"}, 32'({bus_a.x, bus_a.y, bus_a.hsync, bus_a.vsync, bus_a.video_on,
                                      bus_a.line_start, bus_a.frame_start, bus_a.frame_count}), 32'(RST_A));
    checkOutput({tag, "_rst_b"}, 32'({bus_b.x, bus_b.y, bus_b.hsync, bus_b.vsync, bus_b.video_on,
                                      bus_b.line_start, bus_b.frame_start, bus_b.frame_count}), 32'(RST_B));
    checkOutput({tag, "_rst_ptick"}, 32'({bus_a.p_tick, bus_b.p_tick}), 32'(0));
  endtask

  task automatic waitDone(input int limit);
    int g = 0;
    while ((mon_a || mon_b) && g < limit) begin
      @(posedge clk);
      g++;
    end
    if (mon_a || mon_b) failNow("queue_drain");
    mon_a = 1'b0;
    mon_b = 1'b0;
  endtask

  // Monitor A: an output update follows every clk in which p_tick was seen high.
  always @(negedge clk) begin
    if (mon_a) begin
      act_a = {bus_a.x, bus_a.y, bus_a.hsync, bus_a.vsync, bus_a.video_on,
               bus_a.line_start, bus_a.frame_start, bus_a.frame_count};
      checkOutput("a_p_tick", 32'(bus_a.p_tick), 32'(en_a && div_a == A_DIV - 1));
      if (upd_a) begin
        if (q_a.size() == 0) begin
          failNow("a_extra_update");
        end else begin
          exp_a = q_a.pop_front();
          checkOutput("a_pixel", 32'(act_a), 32'(exp_a));
          last_a = exp_a;
          popped_a++;
          if (bus_a.frame_start) begin
            if (fs_cyc_a >= 0)
              checkOutput("a_frame_period", 32'(cyc_a - fs_cyc_a),
                          32'(A_DIV * A_HT * A_VT + stall_a - fs_stall_a));
            fs_cyc_a   = cyc_a;
            fs_stall_a = stall_a;
          end
          if (q_a.size() == 0) mon_a = 1'b0;
        end
      end else begin
        checkOutput("a_hold", 32'({bus_a.x, bus_a.y, bus_a.line_start, bus_a.frame_start}),
                    32'({last_a.x, last_a.y, 2'b00}));
      end
      if (en_a) div_a = (div_a + 1) % A_DIV;
      else      stall_a++;
      cyc_a++;
    end
    upd_a = bus_a.p_tick;
  end

  always @(negedge clk) begin
    if (mon_b) begin
      act_b = {bus_b.x, bus_b.y, bus_b.hsync, bus_b.vsync, bus_b.video_on,
               bus_b.line_start, bus_b.frame_start, bus_b.frame_count};
      checkOutput("b_p_tick", 32'(bus_b.p_tick), 32'(en_b));
      if (upd_b) begin
        if (q_b.size() == 0) begin
          failNow("b_extra_update");
        end else begin
          exp_b = q_b.pop_front();
          checkOutput("b_pixel", 32'(act_b), 32'(exp_b));
          last_b = exp_b;
          if (bus_b.frame_start) begin
            if (fs_cyc_b >= 0) checkOutput("b_frame_period", 32'(cyc_b - fs_cyc_b), 32'(B_HT * B_VT));
            fs_cyc_b = cyc_b;
          end
          if (q_b.size() == 0) mon_b = 1'b0;
        end
      end else begin
        checkOutput("b_hold", 32'({bus_b.x, bus_b.y, bus_b.line_start, bus_b.frame_start}),
                    32'({last_b.x, last_b.y, 2'b00}));
      end
      cyc_b++;
    end
    upd_b = bus_b.p_tick;
  end

  initial begin
    int g;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkResetState("por");

    applyStimulus(5 * A_HT * A_VT + 10, 5 * B_HT * B_VT + 5);

    // Freeze mode A for 37 clk once pixel (5,3) of the second frame has been presented.
    g = 0;
    while (popped_a < A_HT * A_VT + 3 * A_HT + 5 + 1 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 5000) failNow("a_freeze_point");
    #1;
    en_a = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    en_a = 1'b1;
    waitDone(10000);

    // Asynchronous reset between clock edges, checked before the next edge.
    repeat (23) @(posedge clk);
    #2;
    reset_n = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    #1;
    checkResetState("mid");
    repeat (2) @(posedge clk);

    applyStimulus(A_HT * A_VT + 5, B_HT * B_VT + 5);
    waitDone(5000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
